// File: rtl/spi_cmd_sender_pkg.sv
// Shared definitions for the SD-card SPI command path.
// Command indices, R1 layout and the CRC7 step used by command senders.
package spi_cmd_sender_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RESP,
        FINISH
    } state_t;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD16  = 6'd16;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

    localparam int R1_IDLE        = 0;
    localparam int R1_ILLEGAL_CMD = 2;
    localparam int R1_CRC_ERR     = 3;

    localparam logic [7:0] R1_READY = 8'h00;

    // x^7 + x^3 + 1 with the x^7 term implied by the shift
    localparam logic [6:0] CRC7_POLY = 7'h09;

    function automatic logic [6:0] crc7_step(
        input logic [6:0] crc,
        input logic       din
    );
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 accumulator, MSB-first, zero initial value.
// Shared by the command senders of the read and write paths.
module crc7_serial
    import spi_cmd_sender_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       bit_en,
    input  logic       din,
    output logic [6:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (bit_en) begin
            crc <= crc7_step(crc, din);
        end
    end

endmodule

// File: rtl/spi_cmd_sender.sv
// Frames one 48-bit SD SPI command onto MOSI, then polls MISO for R1.
// Runs on externally supplied SCLK edge strobes; SCLK and CS live elsewhere.
module spi_cmd_sender
    import spi_cmd_sender_pkg::*;
#(
    parameter int RESP_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk_posedge,
    input  logic        sclk_negedge,
    input  logic        en,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        in,
    output logic        out,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  response
);

    localparam logic [7:0] TIMEOUT = 8'(RESP_TIMEOUT);

    state_t      state;
    logic [39:0] frame;
    logic [5:0]  bit_cnt;
    logic [7:0]  byte_cnt;
    logic [2:0]  bit_pos;
    logic [7:0]  rx;
    logic        tail;
    logic        byte_full;
    logic [6:0]  crc;
    logic        crc_clr;
    logic        crc_en;

    assign crc_clr = (state == IDLE) && en;
    assign crc_en  = (state == SEND) && sclk_negedge
                   && !tail && (bit_cnt >= 6'd8);

    crc7_serial u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (crc_clr),
        .bit_en (crc_en),
        .din    (frame[39]),
        .crc    (crc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            frame     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            bit_pos   <= '0;
            rx        <= '0;
            tail      <= 1'b0;
            byte_full <= 1'b0;
            out       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            response  <= 8'hFF;
        end else begin
            unique case (state)
                IDLE: begin
                    out <= 1'b1;
                    if (en) begin
                        frame   <= {2'b01, cmd_index, cmd_arg};
                        error   <= 1'b0;
                        bit_cnt <= 6'd47;
                        tail    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (sclk_negedge) begin
                        if (tail) begin
                            out       <= 1'b1;
                            byte_cnt  <= '0;
                            bit_pos   <= 3'd7;
                            byte_full <= 1'b0;
                            tail      <= 1'b0;
                            state     <= RESP;
                        end else begin
                            // CRC is final here; reload the shifter with CRC tail and end bit
                            if (bit_cnt == 6'd7) begin
                                out   <= crc[6];
                                frame <= {crc[5:0], 1'b1, 33'd0};
                            end else begin
                                out   <= frame[39];
                                frame <= {frame[38:0], 1'b0};
                            end
                            if (bit_cnt == 6'd0) begin
                                tail <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt - 6'd1;
                            end
                        end
                    end
                end
                RESP: begin
                    out <= 1'b1;
                    if (byte_full) begin
                        byte_full <= 1'b0;
                        if (!rx[7]) begin
                            response <= rx;
                            done     <= 1'b1;
                            state    <= FINISH;
                        end else if (byte_cnt + 8'd1 == TIMEOUT) begin
                            error    <= 1'b1;
                            response <= 8'hFF;
                            done     <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end else if (sclk_posedge) begin
                        rx[bit_pos] <= in;
                        bit_pos     <= bit_pos - 3'd1;
                        if (bit_pos == 3'd0) begin
                            byte_full <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
